// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared width helpers and default timing constants for the button event controller
package ctrl_pkg;

    localparam int DEBOUNCE_DEFAULT      = 250000;
    localparam int LED_HOLD_DEFAULT      = 5000000;
    localparam int REPEAT_DELAY_DEFAULT  = 25000000;
    localparam int REPEAT_PERIOD_DEFAULT = 5000000;

    // Bits needed to hold the values 0..n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to index n channels.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_event_controller_if.sv
// rtl/button_event_controller_if.sv - ready/valid press-event stream between the controller and the game FSM
interface button_event_controller_if
    import ctrl_pkg::*;
#(
    parameter int N_BTN = 12
) ();

    localparam int CODE_W = idx_w(N_BTN);

    logic              event_valid;
    logic [CODE_W-1:0] event_code;
    logic              event_ready;

    modport master (
        output event_valid,
        output event_code,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_code,
        output event_ready
    );

endinterface

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button: synchroniser, debounce, press pulse, LED stretch, auto-repeat under CTRL_AUTOREPEAT_EN
module btn_channel
    import ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int LED_HOLD_CYCLES = LED_HOLD_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic block_i,
    input  logic raw_i,
    output logic pulse_o,
    output logic level_o,
    output logic led_o
);

    localparam int              DB_W    = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            level_q, level_d;
    logic            level_dly_q;
    logic            suppress_q, suppress_d;
    logic            pulse_q, pulse_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press;
    logic            repeat_fire;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            suppress_q  <= 1'b0;
            pulse_q     <= 1'b0;
            db_cnt_q    <= '0;
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            suppress_q  <= suppress_d;
            pulse_q     <= pulse_d;
            db_cnt_q    <= db_cnt_d;
        end
    end

    // The DEBOUNCE_CYCLES-th consecutive differing sample flips the level.
    // suppress marks a press that began under block, so its delayed rise after unblock is not reported.
    always_comb begin
        db_cnt_d   = '0;
        level_d    = level_q;
        suppress_d = suppress_q;
        if (!block_i && (sync2_q != level_q)) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        if (block_i && sync2_q) begin
            suppress_d = 1'b1;
        end else if (!block_i && !sync2_q && !level_q) begin
            suppress_d = 1'b0;
        end
        press = level_q & ~level_dly_q & ~block_i & ~suppress_q;
    end

`ifdef CTRL_AUTOREPEAT_EN
    localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RP_W   = cnt_w(RP_MAX);

    logic [RP_W-1:0] rep_q, rep_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end

    // Down-counter holds the distance to the next repeat; reaching 1 schedules a pulse.
    always_comb begin
        rep_d       = rep_q;
        repeat_fire = 1'b0;
        if (press) begin
            rep_d = RP_W'(REPEAT_DELAY);
        end else if (!level_q || block_i) begin
            rep_d = '0;
        end else if (rep_q == RP_W'(1)) begin
            repeat_fire = 1'b1;
            rep_d       = RP_W'(REPEAT_PERIOD);
        end else if (rep_q != '0) begin
            rep_d = rep_q - 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    assign pulse_d = press | repeat_fire;

    generate
        if (LED_HOLD_CYCLES == 0) begin : g_led_level
            assign led_o = level_q;
        end else begin : g_led_timer
            localparam int LED_W = cnt_w(LED_HOLD_CYCLES);

            logic [LED_W-1:0] led_q, led_d;

            always_comb begin
                led_d = led_q;
                if (pulse_q) begin
                    led_d = LED_W'(LED_HOLD_CYCLES);
                end else if (led_q != '0) begin
                    led_d = led_q - 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    led_q <= '0;
                end else begin
                    led_q <= led_d;
                end
            end

            assign led_o = (led_q != '0);
        end
    endgenerate

    assign pulse_o = pulse_q;
    assign level_o = level_q;

endmodule

// File: rtl/button_event_controller.sv
// rtl/button_event_controller.sv - N-channel debounced button front end with a prioritised press-event stream
// Optional auto-repeat is built when CTRL_AUTOREPEAT_EN is defined.
module button_event_controller
    import ctrl_pkg::*;
#(
    parameter int N_BTN           = 12,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int LED_HOLD_CYCLES = LED_HOLD_DEFAULT,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      block_controller,
    input  logic [N_BTN-1:0]          controller_input,
    output logic [N_BTN-1:0]          controller_output,
    output logic [N_BTN-1:0]          btn_level,
    output logic [N_BTN-1:0]          LEDR,
    button_event_controller_if.master evt,
    output logic                      overflow
);

    localparam int CODE_W = idx_w(N_BTN);

    logic [N_BTN-1:0]  pulse;
    logic [N_BTN-1:0]  pending_q, pending_d;
    logic [N_BTN-1:0]  cand;
    logic [N_BTN-1:0]  sel_oh;
    logic [N_BTN-1:0]  take_oh;
    logic [CODE_W-1:0] sel_idx;
    logic [CODE_W-1:0] code_q, code_d;
    logic              valid_q, valid_d;
    logic              overflow_q, overflow_d;
    logic              found;
    logic              load;

    generate
        for (genvar g = 0; g < N_BTN; g++) begin : g_chan
            btn_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LED_HOLD_CYCLES (LED_HOLD_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_PERIOD   (REPEAT_PERIOD)
            ) u_chan (
                .clk     (clk),
                .reset   (reset),
                .block_i (block_controller),
                .raw_i   (controller_input[g]),
                .pulse_o (pulse[g]),
                .level_o (btn_level[g]),
                .led_o   (LEDR[g])
            );
        end
    endgenerate

    // Same-cycle pulses are candidates too, so an idle stream shows a press one cycle after its pulse.
    always_comb begin
        load    = !valid_q || evt.event_ready;
        cand    = pending_q | pulse;
        found   = 1'b0;
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (cand[i] && !found) begin
                found     = 1'b1;
                sel_oh[i] = 1'b1;
                sel_idx   = CODE_W'(i);
            end
        end
        take_oh = load ? sel_oh : '0;
        // A loaded bit survives only when it was pending and re-pulsed in the same cycle.
        pending_d  = cand & ~(take_oh & ~(pending_q & pulse));
        overflow_d = overflow_q | (|(pending_q & pulse & ~take_oh));
        valid_d    = valid_q;
        code_d     = code_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                code_d = sel_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q  <= '0;
            valid_q    <= 1'b0;
            code_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end

    assign controller_output = pulse;
    assign evt.event_valid   = valid_q;
    assign evt.event_code    = code_q;
    assign overflow          = overflow_q;

endmodule
